// File: rtl/conv_pkg.sv
// Shared definitions for the conv2d_transpose engine.
// Contents: FSM state enum, default datapath widths, weight width, and helpers
// for the output map dimensions and index widths.
package conv_pkg;

   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_CLEAR   = 3'd1,
      ST_ACCEPT  = 3'd2,
      ST_SCATTER = 3'd3,
      ST_DRAIN   = 3'd4
   } state_e;

   localparam int unsigned DEF_DATA_W = 16;
   localparam int unsigned DEF_ACC_W  = 32;
   localparam int unsigned WGT_W      = 8;

   // Full-padding, stride-1 transposed convolution grows each side by KERNEL-1.
   function automatic int unsigned out_dim(input int unsigned in_dim, input int unsigned k);
      return in_dim + k - 1;
   endfunction

   // Counter/index width that never collapses to zero bits.
   function automatic int unsigned idx_w(input int unsigned n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/conv2d_transpose_acc_buf.sv
// Accumulation buffer for conv2d_transpose: N_ENT x ACC_W register array with
// one shared read-modify-write port (combinational read, synchronous write).
// Ports:
//   clk        clock
//   addr_i     entry address (shared by clear, accumulate and drain read)
//   clr_i      write zero to addr_i
//   acc_i      write rd_data_o + addend_i to addr_i
//   addend_i   value to accumulate
//   rd_data_o  combinational read of addr_i
// Optional macro: CONV2DT_SAT_EN selects clamping accumulation instead of wraparound.
module conv2d_transpose_acc_buf #(
   parameter int unsigned N_ENT  = 36,
   parameter int unsigned ACC_W  = 32,
   parameter int unsigned ADDR_W = 6
) (
   input  logic              clk,
   input  logic [ADDR_W-1:0] addr_i,
   input  logic              clr_i,
   input  logic              acc_i,
   input  logic [ACC_W-1:0]  addend_i,
   output logic [ACC_W-1:0]  rd_data_o
);

   logic [ACC_W-1:0] mem_q [N_ENT];
   logic [ACC_W-1:0] sum_d;

   assign rd_data_o = mem_q[addr_i];

`ifdef CONV2DT_SAT_EN
   // Carry out clamps to all-ones; a clamped entry stays clamped since addends are unsigned.
   logic [ACC_W:0] wide_sum;
   always_comb begin
      wide_sum = {1'b0, rd_data_o} + {1'b0, addend_i};
      sum_d    = wide_sum[ACC_W] ? '1 : wide_sum[ACC_W-1:0];
   end
`else
   always_comb sum_d = rd_data_o + addend_i;
`endif

   // Contents are not reset; the CLEAR phase zeroes every entry before use.
   always_ff @(posedge clk) begin
      if (clr_i) begin
         mem_q[addr_i] <= '0;
      end else if (acc_i) begin
         mem_q[addr_i] <= sum_d;
      end
   end

endmodule

// File: rtl/conv2d_transpose.sv
// Streaming transposed-convolution engine (stride 1, full padding).
// Each input pixel is multiplied by a latched KERNEL x KERNEL weight set and
// scatter-accumulated into an OUT_H x OUT_W buffer, which is then drained
// row-major as a valid/ready stream.
// Ports:
//   clk, rst_n      clock, asynchronous active-low reset
//   start_i         begin a job (honoured only in IDLE)
//   kernel_i        weights, element (i,j) at bits [(i*KERNEL+j)*8 +: 8]
//   in_valid_i/in_ready_o/in_data_i     input pixel stream, row-major
//   out_valid_o/out_ready_i/out_data_o/out_last_o  output stream, row-major
//   busy_o          high in every state except IDLE
//   done_o          one-cycle pulse after the final output handshake
// Optional macro: CONV2DT_SAT_EN enables saturating accumulation.
module conv2d_transpose
   import conv_pkg::*;
#(
   parameter int unsigned IN_HEIGHT = 4,
   parameter int unsigned IN_WIDTH  = 4,
   parameter int unsigned KERNEL    = 3,
   parameter int unsigned DATA_W    = DEF_DATA_W,
   parameter int unsigned ACC_W     = DEF_ACC_W
) (
   input  logic                            clk,
   input  logic                            rst_n,
   input  logic                            start_i,
   input  logic [KERNEL*KERNEL*WGT_W-1:0]  kernel_i,
   input  logic                            in_valid_i,
   output logic                            in_ready_o,
   input  logic [DATA_W-1:0]               in_data_i,
   output logic                            out_valid_o,
   input  logic                            out_ready_i,
   output logic [ACC_W-1:0]                out_data_o,
   output logic                            out_last_o,
   output logic                            busy_o,
   output logic                            done_o
);

   localparam int unsigned OUT_H  = out_dim(IN_HEIGHT, KERNEL);
   localparam int unsigned OUT_W  = out_dim(IN_WIDTH, KERNEL);
   localparam int unsigned N_OUT  = OUT_H * OUT_W;
   localparam int unsigned ADDR_W = idx_w(N_OUT);
   localparam int unsigned ROW_W  = idx_w(IN_HEIGHT);
   localparam int unsigned COL_W  = idx_w(IN_WIDTH);
   localparam int unsigned K_W    = idx_w(KERNEL);
   localparam int unsigned KK     = KERNEL * KERNEL;
   localparam int unsigned KK_W   = idx_w(KK);
   localparam int unsigned PROD_W = DATA_W + WGT_W;

   state_e              state_q, state_d;
   logic [WGT_W-1:0]    kern_q [KK];
   logic [WGT_W-1:0]    kern_d [KK];
   logic [DATA_W-1:0]   pix_q, pix_d;
   logic [ROW_W-1:0]    row_q, row_d;
   logic [COL_W-1:0]    col_q, col_d;
   logic [K_W-1:0]      ki_q, ki_d;
   logic [K_W-1:0]      kj_q, kj_d;
   logic [ADDR_W-1:0]   cnt_q, cnt_d;
   logic                in_ready_q, in_ready_d;
   logic                out_valid_q, out_valid_d;
   logic [ACC_W-1:0]    out_data_q, out_data_d;
   logic                out_last_q, out_last_d;
   logic                busy_q, busy_d;
   logic                done_q, done_d;

   logic [ADDR_W-1:0]   buf_addr;
   logic                buf_clr;
   logic                buf_acc;
   logic [ACC_W-1:0]    buf_rd;
   logic [ACC_W-1:0]    addend;
   logic [PROD_W-1:0]   prod;
   logic [KK_W-1:0]     kidx;
   logic [ADDR_W-1:0]   scat_addr;
   logic                fire;

   // Scatter datapath: weight select, product and target address for (row+i, col+j).
   always_comb begin
      kidx      = KK_W'(32'(ki_q) * KERNEL + 32'(kj_q));
      prod      = PROD_W'(pix_q) * PROD_W'(kern_q[kidx]);
      addend    = ACC_W'(prod);
      scat_addr = ADDR_W'((32'(row_q) + 32'(ki_q)) * OUT_W + 32'(col_q) + 32'(kj_q));
   end

   conv2d_transpose_acc_buf #(
      .N_ENT  (N_OUT),
      .ACC_W  (ACC_W),
      .ADDR_W (ADDR_W)
   ) u_acc_buf (
      .clk       (clk),
      .addr_i    (buf_addr),
      .clr_i     (buf_clr),
      .acc_i     (buf_acc),
      .addend_i  (addend),
      .rd_data_o (buf_rd)
   );

   // Next-state and registered-output logic.
   always_comb begin
      state_d     = state_q;
      kern_d      = kern_q;
      pix_d       = pix_q;
      row_d       = row_q;
      col_d       = col_q;
      ki_d        = ki_q;
      kj_d        = kj_q;
      cnt_d       = cnt_q;
      out_valid_d = out_valid_q;
      out_data_d  = out_data_q;
      out_last_d  = out_last_q;
      done_d      = 1'b0;
      buf_addr    = cnt_q;
      buf_clr     = 1'b0;
      buf_acc     = 1'b0;
      fire        = out_valid_q && out_ready_i;

      case (state_q)
         ST_IDLE: begin
            if (start_i) begin
               for (int k = 0; k < int'(KK); k++) begin
                  kern_d[k] = kernel_i[k*int'(WGT_W) +: WGT_W];
               end
               row_d   = '0;
               col_d   = '0;
               cnt_d   = '0;
               state_d = ST_CLEAR;
            end
         end
         ST_CLEAR: begin
            buf_clr = 1'b1;
            if (cnt_q == ADDR_W'(N_OUT - 1)) begin
               cnt_d   = '0;
               state_d = ST_ACCEPT;
            end else begin
               cnt_d = cnt_q + ADDR_W'(1);
            end
         end
         ST_ACCEPT: begin
            if (in_valid_i && in_ready_q) begin
               pix_d   = in_data_i;
               ki_d    = '0;
               kj_d    = '0;
               state_d = ST_SCATTER;
            end
         end
         ST_SCATTER: begin
            buf_addr = scat_addr;
            buf_acc  = 1'b1;
            if (kj_q == K_W'(KERNEL - 1)) begin
               kj_d = '0;
               if (ki_q == K_W'(KERNEL - 1)) begin
                  ki_d = '0;
                  if (col_q == COL_W'(IN_WIDTH - 1)) begin
                     col_d = '0;
                     if (row_q == ROW_W'(IN_HEIGHT - 1)) begin
                        row_d   = '0;
                        cnt_d   = '0;
                        state_d = ST_DRAIN;
                     end else begin
                        row_d   = row_q + ROW_W'(1);
                        state_d = ST_ACCEPT;
                     end
                  end else begin
                     col_d   = col_q + COL_W'(1);
                     state_d = ST_ACCEPT;
                  end
               end else begin
                  ki_d = ki_q + K_W'(1);
               end
            end else begin
               kj_d = kj_q + K_W'(1);
            end
         end
         ST_DRAIN: begin
            // cnt_q is the next entry to load into the output register; the
            // single buffer port costs one load cycle on entry.
            buf_addr = cnt_q;
            if (out_valid_q && out_last_q) begin
               if (fire) begin
                  out_valid_d = 1'b0;
                  out_last_d  = 1'b0;
                  out_data_d  = '0;
                  done_d      = 1'b1;
                  state_d     = ST_IDLE;
               end
            end else if (!out_valid_q || fire) begin
               out_valid_d = 1'b1;
               out_data_d  = buf_rd;
               out_last_d  = (cnt_q == ADDR_W'(N_OUT - 1));
               cnt_d       = cnt_q + ADDR_W'(1);
            end
         end
         default: state_d = ST_IDLE;
      endcase

      in_ready_d = (state_d == ST_ACCEPT);
      busy_d     = (state_d != ST_IDLE);
   end

   // Control state and registered outputs.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= ST_IDLE;
         row_q       <= '0;
         col_q       <= '0;
         ki_q        <= '0;
         kj_q        <= '0;
         cnt_q       <= '0;
         in_ready_q  <= 1'b0;
         out_valid_q <= 1'b0;
         out_data_q  <= '0;
         out_last_q  <= 1'b0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         row_q       <= row_d;
         col_q       <= col_d;
         ki_q        <= ki_d;
         kj_q        <= kj_d;
         cnt_q       <= cnt_d;
         in_ready_q  <= in_ready_d;
         out_valid_q <= out_valid_d;
         out_data_q  <= out_data_d;
         out_last_q  <= out_last_d;
         busy_q      <= busy_d;
         done_q      <= done_d;
      end
   end

   // Datapath holding registers; only meaningful once loaded by the FSM.
   always_ff @(posedge clk) begin
      kern_q <= kern_d;
      pix_q  <= pix_d;
   end

   assign in_ready_o  = in_ready_q;
   assign out_valid_o = out_valid_q;
   assign out_data_o  = out_data_q;
   assign out_last_o  = out_last_q;
   assign busy_o      = busy_q;
   assign done_o      = done_q;

endmodule
